imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage; generalises the zero/sign/LUI immediate extender.
- Adds branch-target and jump-target formation, shift-amount extraction and illegal-op flagging.
- Registered output behind a valid/ready skid buffer, so it sits between decode and the ID/EX register without breaking stall timing.

Parameters:
- DATA_W, 32, output/PC width.
- IMM_W, 16, immediate field width (must be < DATA_W).
- JIDX_W, 26, jump index width (must be <= DATA_W-2).
- TAG_W, 5, opaque sideband carried alongside each result (e.g. dest reg).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  request valid
- in_ready  out  1  request can be accepted
- in_op  in  3  mode select
- in_imm  in  IMM_W  immediate field
- in_jidx  in  JIDX_W  jump index field
- in_pc4  in  DATA_W  PC+4 of the instruction
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_imm  out  DATA_W  generated value
- out_tag  out  TAG_W  sideband of result
- out_illegal  out  1  result came from an undefined op
- ill_cnt  out  8  saturating count of accepted illegal ops

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid empty, in_ready=1, out_imm=0, out_tag=0, out_illegal=0, ill_cnt=0. Assertion mid-transfer discards all held entries immediately.
- Ops (S = sign-extend in_imm to DATA_W, Z = zero-extend):
  - 000 ZERO: Z.
  - 001 SIGN: S.
  - 010 LUI: in_imm in bits [DATA_W-1:DATA_W-IMM_W], zeros below.
  - 011 BRANCH: in_pc4 + (S<<2), modulo 2^DATA_W.
  - 100 JUMP: {in_pc4[DATA_W-1:JIDX_W+2], in_jidx, 2'b00}.
  - 101 SHAMT: zero-extend in_imm[10:6].
  - 110, 111: value 0 with illegal=1.
- Accept: in_valid && in_ready. The result is computed combinationally from the inputs and captured at that edge. Latency is 1 cycle (accept edge -> out_valid high).
- Storage is a main register (drives outputs) plus one skid entry. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Per-edge rules, flush=0:
  - skid_valid && out_ready: main<=skid, skid emptied.
  - !skid_valid && accept && (!out_valid || out_ready): main<=new.
  - !skid_valid && accept && out_valid && !out_ready: skid<=new, main held.
  - no accept && out_ready: out_valid<=0.
- Order is strictly preserved. Throughput is 1/cycle while out_ready is high. The main register must not change while out_valid && !out_ready.
- flush=1 has priority over everything: out_valid<=0, skid emptied, and any same-cycle accept is discarded (not counted in ill_cnt). Data fields may hold stale values.
- ill_cnt increments by 1 on each accepted, non-flushed illegal op and saturates at 255. It is cleared only by reset, not by flush.
- out_tag and out_illegal travel with their result through both registers.

Test Plan:
- Modes at defaults, out_ready=1:
  - SIGN imm=0x8001 -> 0xFFFF8001.
  - ZERO imm=0x8001 -> 0x00008001.
  - LUI imm=0x1234 -> 0x12340000.
  - SHAMT imm=0x07C0 -> 0x0000001F.
  - Each result has out_valid high exactly one cycle after accept.
- BRANCH pc4=0x00400004, imm=0xFFFF -> 0x00400000. BRANCH pc4=0xFFFFFFFC, imm=0x0001 -> 0x00000000 (wrap). JUMP pc4=0x80000010, jidx=0x0000100 -> 0x80000400.
- Backpressure: out_ready=0, send A (tag 1) then B (tag 2) -> A in main, B in skid, in_ready=0; third request stalls. Raise out_ready -> A, B, C delivered in order on consecutive cycles, no loss or duplication.
- Illegal: op=111 -> out_imm=0, out_illegal=1, ill_cnt=1. 300 back-to-back illegal ops -> ill_cnt=255 and stays there.
- Flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, ill_cnt unchanged; the discarded request never appears.
- Async reset pulse mid-stream (not aligned to clk) -> out_valid, in_ready=1, ill_cnt=0 immediately. After release the first request completes normally.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_pipe : pipelined immediate / branch / jump target generator     |
// |                behind a valid/ready skid buffer with illegal-op count.  |
// | Revision     : 1.0                                                      |
// +--------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [JIDX_W-1:0] in_jidx,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic [7:0]        ill_cnt
);

  localparam logic [2:0] c_OP_ZERO   = 3'd0;
  localparam logic [2:0] c_OP_SIGN   = 3'd1;
  localparam logic [2:0] c_OP_LUI    = 3'd2;
  localparam logic [2:0] c_OP_BRANCH = 3'd3;
  localparam logic [2:0] c_OP_JUMP   = 3'd4;
  localparam logic [2:0] c_OP_SHAMT  = 3'd5;

  // Mask form keeps the jump concat legal even when JIDX_W == DATA_W-2.
  localparam logic [DATA_W-1:0] c_JUMP_HI_MASK = {DATA_W{1'b1}} << (JIDX_W + 2);

  logic [DATA_W-1:0] w_sext, w_zext, w_val;
  logic              w_ill, w_accept;

  assign w_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, in_imm};

  always_comb begin
    w_val = '0;
    w_ill = 1'b0;
    case (in_op)
      c_OP_ZERO:   w_val = w_zext;
      c_OP_SIGN:   w_val = w_sext;
      c_OP_LUI:    w_val = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      c_OP_BRANCH: w_val = in_pc4 + (w_sext << 2);
      c_OP_JUMP:   w_val = (in_pc4 & c_JUMP_HI_MASK)
                         | ({{(DATA_W-JIDX_W){1'b0}}, in_jidx} << 2);
      c_OP_SHAMT:  w_val = {{(DATA_W-5){1'b0}}, in_imm[10:6]};
      default:     w_ill = 1'b1;
    endcase
  end

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_imm_q, main_imm_d;
  logic [TAG_W-1:0]  main_tag_q, main_tag_d;
  logic              main_ill_q, main_ill_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic              skid_ill_q, skid_ill_d;
  logic [7:0]        ill_cnt_q, ill_cnt_d;

  assign w_accept = in_valid && !skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    ill_cnt_d    = ill_cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && out_ready) begin
      main_valid_d = 1'b1;
      main_imm_d   = skid_imm_q;
      main_tag_d   = skid_tag_q;
      main_ill_d   = skid_ill_q;
      skid_valid_d = 1'b0;
    end else if (w_accept && (!main_valid_q || out_ready)) begin
      main_valid_d = 1'b1;
      main_imm_d   = w_val;
      main_tag_d   = in_tag;
      main_ill_d   = w_ill;
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = w_val;
      skid_tag_d   = in_tag;
      skid_ill_d   = w_ill;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end

    if (!flush && w_accept && w_ill && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
      ill_cnt_q    <= 8'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;
  assign ill_cnt     = ill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_gen_pipe : directed + random bench with a 2-deep queue model.    |
// | Revision        : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_jidx = '0;
  logic [31:0] in_pc4 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic        out_illegal;
  logic [7:0]  ill_cnt;

  imm_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_imm(in_imm), .in_jidx(in_jidx), .in_pc4(in_pc4), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal), .ill_cnt(ill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } item_t;

  item_t q[$];
  int    mcnt = 0;
  int    n_vec = 0;
  int    n_err = 0;

  // Reference: the op table evaluated with plain integer arithmetic.
  function automatic item_t ref_item(logic [2:0] op, logic [15:0] imm,
                                     logic [25:0] jidx, logic [31:0] pc4,
                                     logic [4:0] tag);
    item_t it;
    int    s;
    logic [31:0] u, j;
    s = int'($signed(imm));
    u = 32'(imm);
    j = 32'(jidx);
    it.tag = tag;
    it.ill = 1'b0;
    case (op)
      3'd0: it.imm = u;
      3'd1: it.imm = 32'(s);
      3'd2: it.imm = u * 32'd65536;
      3'd3: it.imm = pc4 + 32'(s * 4);
      3'd4: it.imm = (pc4 & 32'hF000_0000) | (j * 32'd4);
      3'd5: it.imm = (u / 32'd64) % 32'd32;
      default: begin it.imm = 32'd0; it.ill = 1'b1; end
    endcase
    return it;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("ill_cnt", 32'(ill_cnt), 32'(mcnt));
    if (q.size() > 0) begin
      chk("out_imm", out_imm, q[0].imm);
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  task automatic tick();
    bit    acc, pop;
    item_t it;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    it  = ref_item(in_op, in_imm, in_jidx, in_pc4, in_tag);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) q.delete(0);
      if (acc) begin
        q.push_back(it);
        if (it.ill && mcnt != 255) mcnt++;
      end
    end
    check_model();
  endtask

  task automatic set_req(input logic v, input logic [2:0] op, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [31:0] pc4, input logic [4:0] tag);
    in_valid = v; in_op = op; in_imm = imm; in_jidx = jidx; in_pc4 = pc4; in_tag = tag;
  endtask

  task automatic one_shot(input string name, input logic [2:0] op, input logic [15:0] imm,
                          input logic [25:0] jidx, input logic [31:0] pc4, input logic [31:0] exp);
    set_req(1'b1, op, imm, jidx, pc4, 5'd9);
    tick();
    chk(name, out_imm, exp);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk({name, "_onecycle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_ill", 32'(out_illegal), 32'd0);
    chk("rst_cnt", 32'(ill_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    one_shot("sign", 3'd1, 16'h8001, 26'd0, 32'd0, 32'hFFFF_8001);
    one_shot("zero", 3'd0, 16'h8001, 26'd0, 32'd0, 32'h0000_8001);
    one_shot("lui", 3'd2, 16'h1234, 26'd0, 32'd0, 32'h1234_0000);
    one_shot("shamt", 3'd5, 16'h07C0, 26'd0, 32'd0, 32'h0000_001F);
    one_shot("branch", 3'd3, 16'hFFFF, 26'd0, 32'h0040_0004, 32'h0040_0000);
    one_shot("branch_wrap", 3'd3, 16'h0001, 26'd0, 32'hFFFF_FFFC, 32'h0000_0000);
    one_shot("jump", 3'd4, 16'd0, 26'h0000100, 32'h8000_0010, 32'h8000_0400);

    // Backpressure: A in main, B in skid, C stalls until space frees.
    out_ready = 1'b0;
    set_req(1'b1, 3'd1, 16'h0011, 26'd0, 32'd0, 5'd1); tick();
    set_req(1'b1, 3'd1, 16'h0022, 26'd0, 32'd0, 5'd2); tick();
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_main_A", 32'(out_tag), 32'd1);
    set_req(1'b1, 3'd1, 16'h0033, 26'd0, 32'd0, 5'd3); tick();
    chk("bp_hold_A", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_B", 32'(out_tag), 32'd2);
    tick();
    chk("bp_C", 32'(out_tag), 32'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    set_req(1'b1, 3'd7, 16'hABCD, 26'd0, 32'd0, 5'd4); tick();
    chk("ill_imm", out_imm, 32'd0);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_cnt1", 32'(ill_cnt), 32'd1);
    in_valid = 1'b0; tick();

    // Flush with both entries held, then flush racing a real accept.
    out_ready = 1'b0;
    set_req(1'b1, 3'd0, 16'h0001, 26'd0, 32'd0, 5'd5); tick();
    set_req(1'b1, 3'd0, 16'h0002, 26'd0, 32'd0, 5'd6); tick();
    set_req(1'b1, 3'd6, 16'h0003, 26'd0, 32'd0, 5'd7);
    flush = 1'b1; tick();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_cnt", 32'(ill_cnt), 32'd1);
    tick();
    chk("fl_acc_cnt", 32'(ill_cnt), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_gone", 32'(out_valid), 32'd0);

    set_req(1'b1, 3'd7, 16'd0, 26'd0, 32'd0, 5'd8);
    repeat (300) tick();
    in_valid = 1'b0; tick();
    chk("sat_cnt", 32'(ill_cnt), 32'd255);
    set_req(1'b1, 3'd6, 16'd0, 26'd0, 32'd0, 5'd8); tick();
    in_valid = 1'b0; tick();
    chk("sat_hold", 32'(ill_cnt), 32'd255);

    // Asynchronous reset pulse between clock edges while both entries are full.
    out_ready = 1'b0;
    set_req(1'b1, 3'd0, 16'h0100, 26'd0, 32'd0, 5'd10); tick();
    set_req(1'b1, 3'd0, 16'h0200, 26'd0, 32'd0, 5'd11); tick();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); mcnt = 0;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_cnt", 32'(ill_cnt), 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    set_req(1'b1, 3'd1, 16'hFFFE, 26'd0, 32'd0, 5'd12); tick();
    chk("ar_first", out_imm, 32'hFFFF_FFFE);
    in_valid = 1'b0; tick();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_op     = 3'($urandom_range(0, 7));
      in_imm    = 16'($urandom);
      in_jidx   = 26'($urandom);
      in_pc4    = $urandom;
      in_tag    = 5'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
